// File: rtl/usb_serial_out_ep_if.sv
// Signal bundle between the OUT endpoint consumer, the protocol engine read bus,
// the stall controls and the downstream byte stream.
interface usb_serial_out_ep_if #(
    parameter int unsigned FIFO_DEPTH = 16
) ();
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          out_ep_req;
    logic          out_ep_grant;
    logic          out_ep_data_avail;
    logic          out_ep_setup;
    logic          out_ep_data_get;
    logic [7:0]    out_ep_data;
    logic          out_ep_stall;
    logic          stall_set;
    logic          stall_clr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [LW-1:0] fifo_level;
    logic [7:0]    setup_drop_cnt;

    // Endpoint side
    modport master (
        output out_ep_req,
        output out_ep_data_get,
        output out_ep_stall,
        output rd_data,
        output rd_valid,
        output fifo_level,
        output setup_drop_cnt,
        input  out_ep_grant,
        input  out_ep_data_avail,
        input  out_ep_setup,
        input  out_ep_data,
        input  stall_set,
        input  stall_clr,
        input  rd_ready
    );

    // Engine / arbiter / consumer side
    modport slave (
        input  out_ep_req,
        input  out_ep_data_get,
        input  out_ep_stall,
        input  rd_data,
        input  rd_valid,
        input  fifo_level,
        input  setup_drop_cnt,
        output out_ep_grant,
        output out_ep_data_avail,
        output out_ep_setup,
        output out_ep_data,
        output stall_set,
        output stall_clr,
        output rd_ready
    );
endinterface

// File: rtl/usb_serial_out_ep.sv
// CDC-ACM bulk OUT endpoint consumer: pulls payload bytes from the protocol engine
// only when the local FIFO has room, and streams them out over valid/ready.
module usb_serial_out_ep #(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter bit          DISCARD_SETUP = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    usb_serial_out_ep_if.master bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW+1:0] DEPTH_W = FIFO_DEPTH[AW+1:0];
    localparam logic [AW:0]   DEPTH_L = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StDrain} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_stall;
    logic        r_inflight;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [7:0]  r_drop_cnt;

    logic        w_req;
    logic        w_get;
    logic        w_space;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic        w_valid;
    logic [AW:0] w_level;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_valid = (w_level != '0);
    // Bytes already requested but not yet landed still need a slot.
    assign w_space = ({1'b0, w_level} + {{(AW + 1){1'b0}}, r_inflight}) < DEPTH_W;
    assign w_drop  = DISCARD_SETUP && r_inflight && bus.out_ep_setup;
    assign w_push  = r_inflight && !w_drop;
    assign w_pop   = w_valid && bus.rd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (bus.out_ep_data_avail && !r_stall) w_state_next = StReq;
            StReq:   if (bus.out_ep_grant) w_state_next = StXfer;
            StXfer: begin
                if (!bus.out_ep_grant) begin
                    w_state_next = StReq;
                end else if (!bus.out_ep_data_avail) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Gated by reset so the engine sees req/get fall in the reset cycle itself.
    always_comb begin
        w_req = 1'b0;
        w_get = 1'b0;
        if (!reset) begin
            case (r_state)
                StReq, StDrain: w_req = 1'b1;
                StXfer: begin
                    w_req = 1'b1;
                    w_get = bus.out_ep_grant && bus.out_ep_data_avail && w_space;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_stall    <= 1'b0;
            r_drop_cnt <= 8'h00;
        end else begin
            assert (!(w_push && w_level == DEPTH_L));
            r_inflight <= w_get;
            r_stall    <= bus.stall_set || (r_stall && !bus.stall_clr);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_drop && r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'h01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.out_ep_data;
        end
    end

    assign bus.out_ep_req      = w_req;
    assign bus.out_ep_data_get = w_get;
    assign bus.out_ep_stall    = r_stall;
    assign bus.rd_valid        = w_valid;
    assign bus.rd_data         = w_valid ? r_mem[r_rd_ptr[AW-1:0]] : 8'h00;
    assign bus.fifo_level      = w_level;
    assign bus.setup_drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_usb_serial_out_ep.sv
// Bench for usb_serial_out_ep: engine model, scoreboard of stored bytes, directed
// scenarios followed by randomized packets with random grant and rd_ready.
module tb_usb_serial_out_ep;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    usb_serial_out_ep_if #(.FIFO_DEPTH(DEPTH)) bus ();

    usb_serial_out_ep #(
        .FIFO_DEPTH   (DEPTH),
        .DISCARD_SETUP(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int get_cnt = 0;
    int drop_model = 0;
    byte unsigned eng_q[$];
    byte unsigned exp_q[$];
    bit rnd_mode = 1'b0;
    bit grant_dir = 1'b0;
    bit ready_dir = 1'b0;

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic drv();
        @(posedge clk);
        #2;
    endtask

    // A packet's non-SETUP bytes must emerge from the FIFO in order.
    task automatic load(input byte unsigned base, input int n, input bit setup);
        bus.out_ep_setup = setup;
        for (int i = 0; i < n; i++) begin
            eng_q.push_back(8'(base + i));
            if (setup) drop_model++;
            else exp_q.push_back(8'(base + i));
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            smp();
            if (eng_q.size() == 0 && !bus.out_ep_req && bus.fifo_level == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, int'(ok), 1);
    endtask

    // Engine: a get in cycle N pops the packet buffer and presents the byte in N+1.
    initial begin
        bit g;
        bus.out_ep_data       = 8'h00;
        bus.out_ep_data_avail = 1'b0;
        forever begin
            @(negedge clk);
            g = bus.out_ep_data_get;
            @(posedge clk);
            #1;
            if (g) begin
                if (eng_q.size() == 0) chk("get_without_data", 1, 0);
                else bus.out_ep_data = eng_q.pop_front();
            end
            bus.out_ep_data_avail = (eng_q.size() != 0);
        end
    end

    initial begin
        bus.out_ep_grant = 1'b0;
        bus.rd_ready     = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (rnd_mode) begin
                bus.out_ep_grant = ($urandom_range(0, 3) != 0);
                bus.rd_ready     = $urandom_range(0, 1) != 0;
            end else begin
                bus.out_ep_grant = grant_dir;
                bus.rd_ready     = ready_dir;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.out_ep_data_get) get_cnt++;
        if (!reset && bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) chk("unexpected_byte", int'(bus.rd_data), -1);
            else chk("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gtr[16], rtr[16], atr[16];
        int g0, g1, fa, la, gf, gl, gn;
        bit flag;
        bus.out_ep_setup = 1'b0;
        bus.stall_set    = 1'b0;
        bus.stall_clr    = 1'b0;
        repeat (3) drv();
        smp();
        chk("rst_req", bus.out_ep_req, 0);
        chk("rst_get", bus.out_ep_data_get, 0);
        drv();
        reset = 1'b0;
        smp();
        chk("rst_stall", bus.out_ep_stall, 0);
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_drop", bus.setup_drop_cnt, 0);
        chk("rst_rdata", bus.rd_data, 0);

        // 5-byte packet, immediate grant, consumer always ready
        grant_dir = 1'b1;
        ready_dir = 1'b1;
        drv();
        load(8'h11, 5, 1'b0);
        for (int c = 0; c < 16; c++) begin
            smp();
            gtr[c] = bus.out_ep_data_get;
            rtr[c] = bus.out_ep_req;
            atr[c] = bus.out_ep_data_avail;
        end
        fa = -1; la = -1; gf = -1; gl = -1; gn = 0;
        for (int c = 0; c < 16; c++) begin
            if (atr[c] && fa < 0) fa = c;
            if (!atr[c] && fa >= 0 && la < 0) la = c;
            if (gtr[c]) begin
                gn++;
                if (gf < 0) gf = c;
                gl = c;
            end
        end
        chk("t1_get_count", gn, 5);
        chk("t1_get_consecutive", gl - gf + 1, 5);
        chk("t1_first_get_latency", gf - fa, 2);
        if (la >= 0 && la + 2 < 16) begin
            chk("t1_req_at_fall", rtr[la], 1);
            chk("t1_req_fall_plus1", rtr[la+1], 1);
            chk("t1_req_fall_plus2", rtr[la+2], 0);
        end else begin
            chk("t1_avail_fall_seen", 0, 1);
        end
        wait_idle("t1_idle");
        chk("t1_level", bus.fifo_level, 0);

        // Backpressure: 8 bytes into a 4-entry FIFO
        drv();
        ready_dir = 1'b0;
        load(8'h20, 8, 1'b0);
        g0 = get_cnt;
        repeat (15) smp();
        chk("t2_gets_full", get_cnt - g0, 4);
        chk("t2_level_full", bus.fifo_level, 4);
        chk("t2_get_low", bus.out_ep_data_get, 0);
        chk("t2_req_held", bus.out_ep_req, 1);
        drv();
        ready_dir = 1'b1;
        repeat (4) smp();
        drv();
        ready_dir = 1'b0;
        repeat (4) smp();
        chk("t2_gets_all", get_cnt - g0, 8);
        chk("t2_level_refill", bus.fifo_level, 4);
        drv();
        ready_dir = 1'b1;
        wait_idle("t2_idle");

        // SETUP packet discarded, then a normal packet stored intact
        drv();
        load(8'hA0, 8, 1'b1);
        wait_idle("t3_setup_idle");
        chk("t3_drop_cnt", bus.setup_drop_cnt, 8);
        drv();
        load(8'h30, 6, 1'b0);
        wait_idle("t3_normal_idle");

        // Grant removed for 3 cycles after the second byte
        drv();
        load(8'h40, 8, 1'b0);
        g0 = get_cnt;
        for (int i = 0; i < 50; i++) begin
            smp();
            if (get_cnt - g0 >= 2) break;
        end
        chk("t4_gets_before_gap", get_cnt - g0, 2);
        drv();
        grant_dir = 1'b0;
        g1 = get_cnt;
        flag = 1'b1;
        repeat (3) begin
            smp();
            if (!bus.out_ep_req) flag = 1'b0;
        end
        chk("t4_gap_gets", get_cnt - g1, 0);
        chk("t4_gap_req", int'(flag), 1);
        drv();
        grant_dir = 1'b1;
        wait_idle("t4_idle");
        chk("t4_gets_total", get_cnt - g0, 8);

        // Stall blocks a new request; clear releases it; set wins over clear
        drv();
        bus.stall_set = 1'b1;
        drv();
        bus.stall_set = 1'b0;
        load(8'h50, 3, 1'b0);
        flag = 1'b0;
        repeat (5) begin
            smp();
            if (bus.out_ep_req) flag = 1'b1;
        end
        chk("t5_req_while_stalled", int'(flag), 0);
        chk("t5_stall_out", bus.out_ep_stall, 1);
        drv();
        bus.stall_clr = 1'b1;
        drv();
        bus.stall_clr = 1'b0;
        smp();
        chk("t5_stall_cleared", bus.out_ep_stall, 0);
        smp();
        chk("t5_req_after_clear", bus.out_ep_req, 1);
        wait_idle("t5_idle");
        drv();
        bus.stall_set = 1'b1;
        bus.stall_clr = 1'b1;
        drv();
        bus.stall_set = 1'b0;
        bus.stall_clr = 1'b0;
        smp();
        chk("t5_set_wins", bus.out_ep_stall, 1);
        drv();
        bus.stall_clr = 1'b1;
        drv();
        bus.stall_clr = 1'b0;
        smp();
        chk("t5_final_clear", bus.out_ep_stall, 0);

        // Reset mid-transfer with three bytes buffered
        drv();
        ready_dir = 1'b0;
        load(8'h60, 8, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            smp();
            if (bus.fifo_level == 3) begin
                flag = 1'b1;
                break;
            end
        end
        chk("t6_three_buffered", int'(flag), 1);
        drv();
        reset = 1'b1;
        eng_q.delete();
        exp_q.delete();
        drop_model = 0;
        smp();
        chk("t6_req_in_reset", bus.out_ep_req, 0);
        chk("t6_get_in_reset", bus.out_ep_data_get, 0);
        smp();
        chk("t6_req_next", bus.out_ep_req, 0);
        chk("t6_get_next", bus.out_ep_data_get, 0);
        chk("t6_valid_next", bus.rd_valid, 0);
        chk("t6_level_next", bus.fifo_level, 0);
        drv();
        reset = 1'b0;
        ready_dir = 1'b1;
        repeat (2) drv();

        // Random packets, random grant and consumer readiness
        rnd_mode = 1'b1;
        for (int p = 0; p < 24; p++) begin
            drv();
            load(8'($urandom_range(0, 255)), $urandom_range(1, 10), $urandom_range(0, 3) == 0);
            wait_idle("rnd_idle");
        end
        rnd_mode = 1'b0;
        repeat (2) smp();
        chk("rnd_drop_cnt", bus.setup_drop_cnt, (drop_model > 255) ? 255 : drop_model);
        chk("end_exp_empty", exp_q.size(), 0);
        chk("end_level", bus.fifo_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_serial_out_ep.md
Name: usb_serial_out_ep

Overview:
- Single OUT endpoint consumer sitting directly downstream of the OUT protocol engine, on the CDC-ACM bulk data OUT endpoint.
- Requests the shared OUT endpoint read bus and pulls received payload bytes out of the protocol engine's packet buffer.
- Pushes those bytes into a local byte FIFO that drains to the serial transmit side over a valid/ready stream.
- Never reads a byte it has no FIFO room for, so flow control back to the host happens through the engine's NAK path.

Parameters:
FIFO_DEPTH, 16, local byte FIFO entries; must be a power of two, minimum 4.
DISCARD_SETUP, 1, 1 = bytes of packets flagged as SETUP are read and dropped, not stored.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
out_ep_req  out  1  request for the OUT read bus
out_ep_grant  in  1  bus grant from the arbiter
out_ep_data_avail  in  1  engine holds an unread payload byte for this endpoint
out_ep_setup  in  1  current packet arrived via a SETUP token
out_ep_data_get  out  1  read strobe; byte appears on out_ep_data next cycle
out_ep_data  in  8  registered read data from the engine
out_ep_stall  out  1  stall request to the engine
stall_set  in  1  pulse: set endpoint stall
stall_clr  in  1  pulse: clear endpoint stall
rd_data  out  8  FIFO head byte
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer accepts rd_data this cycle
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
setup_drop_cnt  out  8  saturating count of dropped SETUP bytes

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; stall flag 0; setup_drop_cnt 0.
- States: IDLE, REQ, XFER, DRAIN.
- IDLE -> REQ when out_ep_data_avail=1 and the stall flag is 0. out_ep_req=1 in REQ, XFER and DRAIN.
- REQ -> XFER when out_ep_grant=1.
- XFER: out_ep_data_get=1 only when out_ep_grant && out_ep_data_avail && (fifo_level + inflight) < FIFO_DEPTH.
  - inflight = registered copy of the previous cycle's out_ep_data_get.
  - When the FIFO is full, get is held low and the state stays XFER; no byte is lost.
- XFER -> DRAIN when out_ep_data_avail=0; DRAIN -> IDLE after one cycle.
- Capture: when inflight=1, out_ep_data is written into the FIFO (exactly one cycle after the get). This also happens in DRAIN.
- SETUP packets: when DISCARD_SETUP=1 and out_ep_setup=1 on the capture cycle, the byte is not written and setup_drop_cnt increments, saturating at 255.
- Grant loss: if out_ep_grant drops in XFER, get is deasserted that cycle, the state returns to REQ, and any in-flight byte is still captured.
- FIFO:
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Pop occurs when rd_valid && rd_ready.
  - rd_data is the head entry combinationally; it is valid whenever rd_valid=1.
  - Pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Push into a full FIFO cannot occur by construction; the assertion checks this.
- Stall:
  - stall_set sets the flag; stall_clr clears it; simultaneous set and clear -> set wins.
  - out_ep_stall = flag.
  - While stalled, no new request starts; an active XFER completes its current packet.
- Reset mid-transfer: state IDLE, req/get drop the same cycle, FIFO flushed, in-flight byte discarded.
- Throughput: one byte per clock when FIFO space is available and rd_ready=1 continuously.

Test Plan:
- Engine model presents a 5-byte packet 0x11..0x15, grant immediate, rd_ready=1 -> get high for 5 consecutive cycles; rd_data sequence 11,12,13,14,15; fifo_level returns to 0; req drops 2 cycles after avail falls.
- FIFO_DEPTH=4, rd_ready=0, 8-byte packet -> exactly 4 gets, fifo_level=4, get low; releasing rd_ready for 4 cycles lets the remaining 4 bytes through in order with none lost or duplicated.
- out_ep_setup=1 with a 8-byte packet 0xA0..0xA7, DISCARD_SETUP=1 -> FIFO stays empty, setup_drop_cnt=8; the following normal packet is stored intact.
- Grant removed for 3 cycles mid-packet (after byte 2) -> get low during the gap, byte 2 still captured; full packet order preserved after grant returns.
- stall_set pulsed while idle with avail=1 -> req stays 0, out_ep_stall=1; stall_clr -> req high next cycle; simultaneous set and clear pulses -> stall=1.
- reset asserted in XFER with 3 bytes buffered -> next cycle req=0, get=0, rd_valid=0, fifo_level=0.
